// File: rtl/pcie_thruput_meter.sv
// Multi-channel dword throughput meter: windowed accumulation, snapshot latch, registered readback.
// Optional per-channel peak registers are built when THRUPUT_PEAK_EN is defined.
module pcie_thruput_meter #(
  parameter int NUM_CH = 2,
  parameter int INC_W  = 3,
  parameter int CNT_W  = 32,
  parameter int WIN_W  = 27,
  parameter int SEL_W  = 5
) (
  input  logic                    clk_125,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH-1:0]       ch_ready,
  input  logic [NUM_CH*INC_W-1:0] ch_inc,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    mode,
  input  logic [WIN_W-1:0]        window,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [CNT_W-1:0]        rd_data,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH-1:0]       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(32'd1);
  localparam logic [WIN_W-1:0] WIN_TWO  = WIN_W'(32'd2);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  state_t state_r, state_s;

  logic [WIN_W-1:0]              win_len_r, win_len_s;
  logic [WIN_W-1:0]              timer_r, timer_s;
  logic                          cont_r, cont_s;
  logic [NUM_CH-1:0][CNT_W-1:0]  acc_r, acc_s;
  logic [NUM_CH-1:0]             pend_r, pend_s;
  logic [NUM_CH-1:0][CNT_W-1:0]  snap_r, snap_s;
  logic [NUM_CH-1:0]             ovf_r, ovf_s;
  logic [CNT_W-1:0]              nwin_r, nwin_s;
`ifdef THRUPUT_PEAK_EN
  logic [NUM_CH-1:0][CNT_W-1:0]  peak_r, peak_s;
`endif
  logic                          busy_r, busy_s;
  logic                          done_r, done_s;
  logic [CNT_W-1:0]              rd_r, rd_s;
  logic [CNT_W:0]                sum_s;
  logic [NUM_CH-1:0]             hit_s;
  logic [NUM_CH-1:0][INC_W-1:0]  inc_s;
  int                            sel_s;

  assign hit_s = ch_valid & ch_ready;
  assign inc_s = ch_inc;
  assign sel_s = int'(rd_sel);

  assign rd_data  = rd_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = ovf_r;

  // Returns {carry, value}; value clamps to all-ones when the add would wrap.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                             input logic [INC_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(b);
    if (sum[CNT_W]) begin
      sat_add = {1'b1, {CNT_W{1'b1}}};
    end else begin
      sat_add = sum;
    end
  endfunction

  // State register.
  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; stop outranks the RUN->LATCH step and the LATCH exit.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = ARM;
        else       state_s = IDLE;
      end
      ARM: begin
        if (stop) state_s = IDLE;
        else      state_s = RUN;
      end
      RUN: begin
        if (stop)                   state_s = IDLE;
        else if (timer_r == WIN_ZERO) state_s = LATCH;
        else                        state_s = RUN;
      end
      LATCH: begin
        if (stop)        state_s = IDLE;
        else if (cont_r) state_s = RUN;
        else             state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode, registered below alongside the datapath.
  always_comb begin
    busy_s = (state_s != IDLE);
    done_s = (state_r == LATCH) && !stop;
  end

  // Datapath next values: window timer, accumulators, snapshots, counters.
  always_comb begin
    win_len_s = win_len_r;
    cont_s    = cont_r;
    timer_s   = timer_r;
    acc_s     = acc_r;
    pend_s    = pend_r;
    snap_s    = snap_r;
    ovf_s     = ovf_r;
    nwin_s    = nwin_r;
    sum_s     = {(CNT_W+1){1'b0}};
`ifdef THRUPUT_PEAK_EN
    peak_s    = peak_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          win_len_s = (window < WIN_TWO) ? WIN_TWO : window;
          cont_s    = mode;
          nwin_s    = CNT_ZERO;
`ifdef THRUPUT_PEAK_EN
          peak_s    = {(NUM_CH*CNT_W){1'b0}};
`endif
        end else begin
          cont_s    = cont_r;
        end
      end
      ARM: begin
        acc_s   = {(NUM_CH*CNT_W){1'b0}};
        pend_s  = {NUM_CH{1'b0}};
        timer_s = win_len_r - WIN_ONE;
      end
      RUN: begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (hit_s[c]) begin
            sum_s     = sat_add(acc_r[c], inc_s[c]);
            acc_s[c]  = sum_s[CNT_W-1:0];
            pend_s[c] = pend_r[c] | sum_s[CNT_W];
          end else begin
            acc_s[c]  = acc_r[c];
          end
        end
        if (timer_r != WIN_ZERO) timer_s = timer_r - WIN_ONE;
        else                     timer_s = timer_r;
      end
      LATCH: begin
        if (!stop) begin
          snap_s = acc_r;
          ovf_s  = pend_r;
          nwin_s = nwin_r + CNT_ONE;
`ifdef THRUPUT_PEAK_EN
          for (int c = 0; c < NUM_CH; c++) begin
            peak_s[c] = (acc_r[c] > peak_r[c]) ? acc_r[c] : peak_r[c];
          end
`endif
          if (cont_r) begin
            // The LATCH-cycle beat opens the next window so none are lost.
            for (int c = 0; c < NUM_CH; c++) begin
              acc_s[c] = hit_s[c] ? CNT_W'(inc_s[c]) : CNT_ZERO;
            end
            pend_s  = {NUM_CH{1'b0}};
            timer_s = win_len_r - WIN_TWO;
          end else begin
            acc_s   = acc_r;
          end
        end else begin
          snap_s = snap_r;
        end
      end
      default: timer_s = timer_r;
    endcase
  end

  // Readback mux built from next-state values so a fresh snapshot is visible with done.
  always_comb begin
    rd_s = CNT_ZERO;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_s = rd_s | ((sel_s == c) ? snap_s[c] : CNT_ZERO);
`ifdef THRUPUT_PEAK_EN
      rd_s = rd_s | ((sel_s == NUM_CH + 1 + c) ? peak_s[c] : CNT_ZERO);
`endif
    end
    rd_s = rd_s | ((sel_s == NUM_CH) ? nwin_s : CNT_ZERO);
  end

  // Datapath and output registers.
  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      win_len_r <= WIN_TWO;
      cont_r    <= 1'b0;
      timer_r   <= WIN_ZERO;
      acc_r     <= {(NUM_CH*CNT_W){1'b0}};
      pend_r    <= {NUM_CH{1'b0}};
      snap_r    <= {(NUM_CH*CNT_W){1'b0}};
      ovf_r     <= {NUM_CH{1'b0}};
      nwin_r    <= CNT_ZERO;
`ifdef THRUPUT_PEAK_EN
      peak_r    <= {(NUM_CH*CNT_W){1'b0}};
`endif
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_r      <= CNT_ZERO;
    end else begin
      win_len_r <= win_len_s;
      cont_r    <= cont_s;
      timer_r   <= timer_s;
      acc_r     <= acc_s;
      pend_r    <= pend_s;
      snap_r    <= snap_s;
      ovf_r     <= ovf_s;
      nwin_r    <= nwin_s;
`ifdef THRUPUT_PEAK_EN
      peak_r    <= peak_s;
`endif
      busy_r    <= busy_s;
      done_r    <= done_s;
      rd_r      <= rd_s;
    end
  end

endmodule

// File: tb/tb_pcie_thruput_meter.sv
// Directed self-checking bench for pcie_thruput_meter (NUM_CH=2, CNT_W=8).
module tb_pcie_thruput_meter;

  localparam int NUM_CH = 2;
  localparam int INC_W  = 3;
  localparam int CNT_W  = 8;
  localparam int WIN_W  = 27;
  localparam int SEL_W  = 5;

  logic                    clk_125 = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH-1:0]       ch_ready;
  logic [NUM_CH*INC_W-1:0] ch_inc;
  logic                    start;
  logic                    stop;
  logic                    mode;
  logic [WIN_W-1:0]        window;
  logic [SEL_W-1:0]        rd_sel;
  logic [CNT_W-1:0]        rd_data;
  logic                    busy;
  logic                    done;
  logic [NUM_CH-1:0]       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_seen = 0;
  int done_cyc = -1;

  pcie_thruput_meter #(
    .NUM_CH(NUM_CH), .INC_W(INC_W), .CNT_W(CNT_W), .WIN_W(WIN_W), .SEL_W(SEL_W)
  ) dut (
    .clk_125(clk_125), .rst(rst), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch_inc(ch_inc), .start(start), .stop(stop), .mode(mode), .window(window),
    .rd_sel(rd_sel), .rd_data(rd_data), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk_125 = ~clk_125;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one clock and observe 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_125);
    #1;
    cyc++;
    if (done === 1'b1) begin
      done_seen++;
      done_cyc = cyc;
    end
  endtask

  task automatic set_ch(input int c, input logic v, input logic r, input logic [INC_W-1:0] inc);
    ch_valid[c] = v;
    ch_ready[c] = r;
    ch_inc[c*INC_W +: INC_W] = inc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rd(input logic [SEL_W-1:0] sel);
    rd_sel = sel;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ch_valid = '0; ch_ready = '0; ch_inc = '0;
    start = 1'b0; stop = 1'b0; mode = 1'b0; window = 27'd10; rd_sel = 5'd0;
    repeat (3) @(posedge clk_125);
    #1;
    n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (overflow !== 2'b00) begin n_bad++; $display("FAIL reset_overflow: got %b want 00", overflow); end
    rst = 1'b0;
    rd(5'd2);
    n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("FAIL reset_wincount: got %0d want 0", rd_data); end
  endtask

  task automatic test_oneshot();
    int s;
    set_ch(0, 1'b1, 1'b1, 3'd4);
    set_ch(1, 1'b0, 1'b1, 3'd0);
    window = 27'd10; mode = 1'b0;
    done_seen = 0;
    pulse_start();
    s = cyc;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL oneshot_busy_start: got %b want 1", busy); end
    repeat (20) tick();
    n_cmp++; if (done_seen !== 1) begin n_bad++; $display("FAIL oneshot_done_count: got %0d want 1", done_seen); end
    n_cmp++; if (done_cyc - s !== 12) begin n_bad++; $display("FAIL oneshot_done_latency: got %0d want 12", done_cyc - s); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL oneshot_busy_end: got %b want 0", busy); end
    rd(5'd0);
    n_cmp++; if (rd_data !== 8'd40) begin n_bad++; $display("FAIL oneshot_snap0: got %0d want 40", rd_data); end
    rd(5'd1);
    n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("FAIL oneshot_snap1: got %0d want 0", rd_data); end
    rd(5'd2);
    n_cmp++; if (rd_data !== 8'd1) begin n_bad++; $display("FAIL oneshot_wincount: got %0d want 1", rd_data); end
  endtask

  task automatic test_continuous();
    int s;
    int prev;
    int ndone;
    set_ch(0, 1'b0, 1'b0, 3'd0);
    set_ch(1, 1'b1, 1'b1, 3'd1);
    window = 27'd8; mode = 1'b1;
    rd_sel = 5'd1;
    prev = -1; ndone = 0;
    pulse_start();
    s = cyc;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        n_cmp++; if (rd_data !== 8'd8) begin n_bad++; $display("FAIL cont_snap1: got %0d want 8", rd_data); end
        if (prev < 0) begin
          n_cmp++; if (cyc - s !== 10) begin n_bad++; $display("FAIL cont_first_done: got %0d want 10", cyc - s); end
        end else begin
          n_cmp++; if (cyc - prev !== 8) begin n_bad++; $display("FAIL cont_period: got %0d want 8", cyc - prev); end
        end
        prev = cyc;
      end
    end
    n_cmp++; if (ndone !== 4) begin n_bad++; $display("FAIL cont_done_count: got %0d want 4", ndone); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_stop_busy: got %b want 0", busy); end
    rd(5'd2);
    n_cmp++; if (rd_data !== 8'd4) begin n_bad++; $display("FAIL cont_wincount: got %0d want 4", rd_data); end
  endtask

  task automatic test_overflow();
    set_ch(0, 1'b1, 1'b1, 3'd7);
    set_ch(1, 1'b0, 1'b0, 3'd0);
    window = 27'd100; mode = 1'b0;
    pulse_start();
    repeat (110) tick();
    n_cmp++; if (overflow !== 2'b01) begin n_bad++; $display("FAIL ovf_flag_set: got %b want 01", overflow); end
    rd(5'd0);
    n_cmp++; if (rd_data !== 8'd255) begin n_bad++; $display("FAIL ovf_snap_sat: got %0d want 255", rd_data); end
    set_ch(0, 1'b1, 1'b1, 3'd1);
    pulse_start();
    repeat (110) tick();
    n_cmp++; if (overflow !== 2'b00) begin n_bad++; $display("FAIL ovf_flag_clear: got %b want 00", overflow); end
    rd(5'd0);
    n_cmp++; if (rd_data !== 8'd100) begin n_bad++; $display("FAIL ovf_snap_next: got %0d want 100", rd_data); end
  endtask

  task automatic test_stop();
    set_ch(0, 1'b1, 1'b1, 3'd2);
    window = 27'd10; mode = 1'b0;
    done_seen = 0;
    pulse_start();
    repeat (10) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b want 0", busy); end
    repeat (5) tick();
    n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL stop_no_done: got %0d want 0", done_seen); end
    rd(5'd0);
    n_cmp++; if (rd_data !== 8'd100) begin n_bad++; $display("FAIL stop_snap_kept: got %0d want 100", rd_data); end
    rd(5'd2);
    n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("FAIL stop_wincount_cleared: got %0d want 0", rd_data); end
  endtask

  task automatic test_reset_mid();
    rd(5'd0);
    n_cmp++; if (rd_data !== 8'd100) begin n_bad++; $display("FAIL rstmid_pre: got %0d want 100", rd_data); end
    set_ch(0, 1'b1, 1'b1, 3'd4);
    window = 27'd10; mode = 1'b0;
    done_seen = 0;
    pulse_start();
    repeat (5) tick();
    rst = 1'b1;
    @(negedge clk_125);
    n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("FAIL rstmid_rd_data: got %0d want 0", rd_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    n_cmp++; if (overflow !== 2'b00) begin n_bad++; $display("FAIL rstmid_overflow: got %b want 00", overflow); end
    rst = 1'b0;
    repeat (15) tick();
    n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d want 0", done_seen); end
    n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("FAIL rstmid_snap0: got %0d want 0", rd_data); end
  endtask

  task automatic test_peak();
    logic [CNT_W-1:0] exp_peak;
`ifdef THRUPUT_PEAK_EN
    exp_peak = 8'd50;
`else
    exp_peak = 8'd0;
`endif
    set_ch(0, 1'b1, 1'b1, 3'd2);
    set_ch(1, 1'b0, 1'b0, 3'd0);
    window = 27'd10; mode = 1'b1;
    done_seen = 0;
    pulse_start();
    repeat (11) tick();
    set_ch(0, 1'b1, 1'b1, 3'd5);
    repeat (10) tick();
    set_ch(0, 1'b1, 1'b1, 3'd3);
    repeat (11) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_cmp++; if (done_seen !== 3) begin n_bad++; $display("FAIL peak_done_count: got %0d want 3", done_seen); end
    rd(5'd0);
    n_cmp++; if (rd_data !== 8'd30) begin n_bad++; $display("FAIL peak_last_snap: got %0d want 30", rd_data); end
    rd(5'd2);
    n_cmp++; if (rd_data !== 8'd3) begin n_bad++; $display("FAIL peak_wincount: got %0d want 3", rd_data); end
    rd(5'd3);
    n_cmp++; if (rd_data !== exp_peak) begin n_bad++; $display("FAIL peak_ch0: got %0d want %0d", rd_data, exp_peak); end
    rd(5'd4);
    n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("FAIL peak_ch1: got %0d want 0", rd_data); end
    rd(5'd31);
    n_cmp++; if (rd_data !== 8'd0) begin n_bad++; $display("FAIL sel_unused: got %0d want 0", rd_data); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_continuous();
    test_overflow();
    test_stop();
    test_reset_mid();
    test_peak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
